// File: rtl/noc_inbuf_bank.sv
// Bank of independent per-port FWFT input FIFOs with backpressure mask, occupancy and sticky overflow.
// Optional same-cycle bypass of an empty FIFO is enabled by defining NOC_INBUF_BYPASS_EN.
module noc_inbuf_bank #(
    parameter int NPORTS    = 5,
    parameter int FLIT_W    = 16,
    parameter int DEPTH     = 4,
    parameter int AF_MARGIN = 1,
    localparam int CW       = $clog2(DEPTH) + 1,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NPORTS-1:0]        valid_i,
    input  logic [NPORTS*FLIT_W-1:0] data_i,
    input  logic [NPORTS-1:0]        pop_req_i,
    output logic [NPORTS*FLIT_W-1:0] q_o,
    output logic [NPORTS-1:0]        q_valid_o,
    output logic [NPORTS-1:0]        mask_o,
    output logic [NPORTS*CW-1:0]     count_o,
    output logic [NPORTS-1:0]        ovf_o
);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(DEPTH - AF_MARGIN);

    genvar gi;
    generate
        for (gi = 0; gi < NPORTS; gi++) begin : g_port
            logic [AW-1:0]     wptr_q, wptr_d;
            logic [AW-1:0]     rptr_q, rptr_d;
            logic [CW-1:0]     count_q, count_d;
            logic              ovf_q, ovf_d;
            logic [FLIT_W-1:0] mem_q [DEPTH];
            logic [FLIT_W-1:0] din;
            logic              empty, full, pop_ok, push_ok, bypass_take;

            assign din = data_i[gi*FLIT_W +: FLIT_W];

            always_comb begin
                empty   = (count_q == '0);
                full    = (count_q == FULL_CNT);
                pop_ok  = pop_req_i[gi] && !empty;
`ifdef NOC_INBUF_BYPASS_EN
                // Flit handed straight to the allocator never touches the RAM.
                bypass_take = empty && valid_i[gi] && pop_req_i[gi];
`else
                bypass_take = 1'b0;
`endif
                push_ok = valid_i[gi] && (!full || pop_ok) && !bypass_take;
                wptr_d  = wptr_q + AW'(push_ok);
                rptr_d  = rptr_q + AW'(pop_ok);
                case ({push_ok, pop_ok})
                    2'b10:   count_d = count_q + 1'b1;
                    2'b01:   count_d = count_q - 1'b1;
                    default: count_d = count_q;
                endcase
                ovf_d = ovf_q | (valid_i[gi] && full && !pop_ok);
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    wptr_q  <= '0;
                    rptr_q  <= '0;
                    count_q <= '0;
                    ovf_q   <= 1'b0;
                end else begin
                    wptr_q  <= wptr_d;
                    rptr_q  <= rptr_d;
                    count_q <= count_d;
                    ovf_q   <= ovf_d;
                end
            end

            // Storage is deliberately left out of reset.
            always_ff @(posedge clk) begin
                if (push_ok) begin
                    mem_q[wptr_q] <= din;
                end
            end

`ifdef NOC_INBUF_BYPASS_EN
            assign q_valid_o[gi]               = !empty || valid_i[gi];
            assign q_o[gi*FLIT_W +: FLIT_W]    = empty ? din : mem_q[rptr_q];
`else
            assign q_valid_o[gi]               = !empty;
            assign q_o[gi*FLIT_W +: FLIT_W]    = mem_q[rptr_q];
`endif
            assign mask_o[gi]                  = (count_q >= AF_CNT);
            assign count_o[gi*CW +: CW]        = count_q;
            assign ovf_o[gi]                   = ovf_q;
        end
    endgenerate

endmodule

// File: tb/tb_noc_inbuf_bank.sv
// Scoreboard bench for noc_inbuf_bank at default parameters (5 ports, 16-bit flits, depth 4, margin 1).
module tb_noc_inbuf_bank;
    localparam int NP = 5;
    localparam int FW = 16;
    localparam int DP = 4;
    localparam int AF = 1;
    localparam int CW = $clog2(DP) + 1;

    logic                clk;
    logic                rst;
    logic [NP-1:0]       valid_i;
    logic [NP*FW-1:0]    data_i;
    logic [NP-1:0]       pop_req_i;
    logic [NP*FW-1:0]    q_o;
    logic [NP-1:0]       q_valid_o;
    logic [NP-1:0]       mask_o;
    logic [NP*CW-1:0]    count_o;
    logic [NP-1:0]       ovf_o;

    noc_inbuf_bank #(.NPORTS(NP), .FLIT_W(FW), .DEPTH(DP), .AF_MARGIN(AF)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .data_i(data_i), .pop_req_i(pop_req_i),
        .q_o(q_o), .q_valid_o(q_valid_o), .mask_o(mask_o), .count_o(count_o), .ovf_o(ovf_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [FW-1:0] sb_q [NP][$];
    logic [NP-1:0] ovf_m;
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h @%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [NP*FW-1:0] one(input int p, input logic [FW-1:0] v);
        logic [NP*FW-1:0] r;
        r = '0;
        r[p*FW +: FW] = v;
        return r;
    endfunction

    task automatic check_all();
        for (int p = 0; p < NP; p++) begin
            int sz;
            sz = sb_q[p].size();
            check_eq($sformatf("count p%0d", p), 32'(count_o[p*CW +: CW]), 32'(sz));
            check_eq($sformatf("qvalid p%0d", p), 32'(q_valid_o[p]), 32'(sz > 0));
            check_eq($sformatf("mask p%0d", p), 32'(mask_o[p]), 32'(sz >= DP - AF));
            check_eq($sformatf("ovf p%0d", p), 32'(ovf_o[p]), 32'(ovf_m[p]));
            if (sz > 0)
                check_eq($sformatf("head p%0d", p), 32'(q_o[p*FW +: FW]), 32'(sb_q[p][0]));
        end
    endtask

    // One clock cycle: drive, check pre-edge outputs, update model at the edge, check post-edge.
    task automatic cycle(input logic [NP-1:0] v, input logic [NP*FW-1:0] d, input logic [NP-1:0] pr);
        logic [FW-1:0] dp;
        int sz;
        bit pop_ok;
        valid_i   = v;
        data_i    = d;
        pop_req_i = pr;
        #1;
        for (int p = 0; p < NP; p++) begin
            dp = d[p*FW +: FW];
            if (sb_q[p].size() == 0) begin
`ifdef NOC_INBUF_BYPASS_EN
                check_eq($sformatf("byp qvalid p%0d", p), 32'(q_valid_o[p]), 32'(v[p]));
                if (v[p]) check_eq($sformatf("byp data p%0d", p), 32'(q_o[p*FW +: FW]), 32'(dp));
`else
                check_eq($sformatf("empty qvalid p%0d", p), 32'(q_valid_o[p]), 32'd0);
`endif
            end else if (pr[p]) begin
                check_eq($sformatf("pop data p%0d", p), 32'(q_o[p*FW +: FW]), 32'(sb_q[p][0]));
            end
        end
        @(posedge clk);
        for (int p = 0; p < NP; p++) begin
            dp = d[p*FW +: FW];
            sz = sb_q[p].size();
            pop_ok = pr[p] && (sz > 0);
`ifdef NOC_INBUF_BYPASS_EN
            if (sz == 0 && v[p] && pr[p]) continue;
`endif
            if (pop_ok) void'(sb_q[p].pop_front());
            if (v[p]) begin
                if (sz < DP || pop_ok) sb_q[p].push_back(dp);
                else ovf_m[p] = 1'b1;
            end
        end
        #1;
        valid_i   = '0;
        pop_req_i = '0;
        check_all();
    endtask

    initial begin
        logic [NP*FW-1:0] rd;
        rst = 1'b1;
        valid_i = '0;
        pop_req_i = '0;
        data_i = '0;
        ovf_m = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_all();

        // Port 2: fill to full, then an overflowing push, then drain.
        for (int i = 0; i < 4; i++) cycle(5'b00100, one(2, 16'hA001 + 16'(i)), '0);
        cycle(5'b00100, one(2, 16'hBEEF), '0);
        for (int i = 0; i < 4; i++) cycle('0, '0, 5'b00100);

        // Port 4: simultaneous push/pop across the pointer wrap, then on a full FIFO.
        cycle(5'b10000, one(4, 16'hC000), '0);
        for (int i = 1; i <= 10; i++) cycle(5'b10000, one(4, 16'hC000 + 16'(i)), 5'b10000);
        for (int i = 0; i < 3; i++) cycle(5'b10000, one(4, 16'hC100 + 16'(i)), '0);
        cycle(5'b10000, one(4, 16'hC1FF), 5'b10000);
        for (int i = 0; i < 4; i++) cycle('0, '0, 5'b10000);

        // Port 0: push and pop together on an empty FIFO.
        cycle(5'b00001, one(0, 16'h1234), 5'b00001);
        cycle('0, '0, 5'b00001);

        // Random traffic on all ports.
        for (int i = 0; i < 80; i++) begin
            rd = {16'(($urandom())), $urandom(), $urandom()};
            cycle(5'($urandom()), rd, 5'($urandom()));
        end

        // Drain, load two flits per port, then reset mid-cycle.
        for (int i = 0; i < DP; i++) cycle('0, '0, '1);
        cycle('1, {16'h5001, 16'h4001, 16'h3001, 16'h2001, 16'h1001}, '0);
        cycle('1, {16'h5002, 16'h4002, 16'h3002, 16'h2002, 16'h1002}, '0);
        #1;
        rst = 1'b1;
        #1;
        for (int p = 0; p < NP; p++) sb_q[p].delete();
        ovf_m = '0;
        check_all();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_all();
        cycle(5'b00010, one(1, 16'h7777), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
